// File: rtl/drw_linectrl.sv
// drw_linectrl: line-transfer responder for the draw pipeline.
// Splits a kicked line into bursts of up to BURST_MAX pixels, reads destination
// and texture pixels as needed, streams pairs to the pixel processor, collects
// the results and burst-writes them back to the destination.
// Optional build macro DRW_LINECTRL_PERF_EN adds the LINE_CYCLES counter output.
`timescale 1ns/1ps
module drw_linectrl #(
  parameter int BURST_MAX = 16,
  parameter int LW        = 5
) (
  input  logic          CLK,
  input  logic          ARST,
  input  logic          SOFT_RST,
  input  logic          LINE_START,
  output logic          LINE_BUSY,
  input  logic [31:0]   LINE_ADDR_DST,
  input  logic [31:0]   LINE_ADDR_SRC,
  input  logic [10:0]   LINE_LEN,
  input  logic          CMD_MODE,
  input  logic          PARAM_BLEND,
  output logic          RD_REQ,
  output logic [31:0]   RD_ADDR,
  output logic [LW-1:0] RD_LEN,
  input  logic          RD_ACK,
  input  logic          RD_VALID,
  input  logic [31:0]   RD_DATA,
  output logic          PP_VALID,
  output logic [31:0]   PP_DST,
  output logic [31:0]   PP_SRC,
  input  logic          PP_READY,
  input  logic          RES_VALID,
  input  logic [31:0]   RES_DATA,
  output logic          WR_REQ,
  output logic [31:0]   WR_ADDR,
  output logic [LW-1:0] WR_LEN,
  input  logic          WR_ACK,
  output logic [31:0]   WR_DATA,
`ifdef DRW_LINECTRL_PERF_EN
  output logic [31:0]   LINE_CYCLES,
`endif
  input  logic          WR_DRD
);

  localparam int IW = LW - 1;
  localparam logic [LW-1:0] ONE_L = LW'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHUNK, S_RD_DST_REQ, S_RD_DST_DAT, S_RD_SRC_REQ,
    S_RD_SRC_DAT, S_PROC, S_WR_REQ, S_WR_DAT, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   dst_ptr, src_ptr;
  logic [10:0]   remaining;
  logic [LW-1:0] clen, rd_cnt, pp_idx, res_cnt, wr_idx;
  logic          mode, blend;
  logic          rd_last, wr_last, res_take;

  logic [31:0] dst_buf [BURST_MAX];
  logic [31:0] src_buf [BURST_MAX];
  logic [31:0] res_buf [BURST_MAX];

  assign rd_last  = RD_VALID && (rd_cnt == clen - ONE_L);
  assign wr_last  = WR_DRD && (wr_idx == clen - ONE_L);
  assign res_take = (state == S_PROC) && RES_VALID && (res_cnt != clen);

  // State register; abort paths are handled in the next-state logic.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state sequencing through chunk, reads, processing and write-back.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (LINE_START) state_nxt = (LINE_LEN == 11'd0) ? S_DONE : S_CHUNK;
      S_CHUNK:      state_nxt = blend ? S_RD_DST_REQ : (mode ? S_RD_SRC_REQ : S_PROC);
      S_RD_DST_REQ: if (RD_ACK) state_nxt = S_RD_DST_DAT;
      S_RD_DST_DAT: if (rd_last) state_nxt = mode ? S_RD_SRC_REQ : S_PROC;
      S_RD_SRC_REQ: if (RD_ACK) state_nxt = S_RD_SRC_DAT;
      S_RD_SRC_DAT: if (rd_last) state_nxt = S_PROC;
      S_PROC:       if (res_cnt == clen) state_nxt = S_WR_REQ;
      S_WR_REQ:     if (WR_ACK) state_nxt = S_WR_DAT;
      S_WR_DAT:     if (wr_last) state_nxt = (remaining == 11'(clen)) ? S_DONE : S_CHUNK;
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
    if (SOFT_RST) state_nxt = S_IDLE;
  end

  // Output decode; every output is quiet while no request or transfer is active.
  always_comb begin
    LINE_BUSY = (state != S_IDLE) || LINE_START;
    RD_REQ    = (state == S_RD_DST_REQ) || (state == S_RD_SRC_REQ);
    RD_ADDR   = '0;
    RD_LEN    = '0;
    if (state == S_RD_DST_REQ) RD_ADDR = dst_ptr;
    if (state == S_RD_SRC_REQ) RD_ADDR = src_ptr;
    if (RD_REQ) RD_LEN = clen;
    PP_VALID  = (state == S_PROC) && (pp_idx != clen);
    PP_DST    = (PP_VALID && blend) ? dst_buf[pp_idx[IW-1:0]] : 32'd0;
    PP_SRC    = (PP_VALID && mode)  ? src_buf[pp_idx[IW-1:0]] : 32'd0;
    WR_REQ    = (state == S_WR_REQ);
    WR_ADDR   = WR_REQ ? dst_ptr : 32'd0;
    WR_LEN    = WR_REQ ? clen : '0;
    WR_DATA   = (state == S_WR_DAT) ? res_buf[wr_idx[IW-1:0]] : 32'd0;
  end

  // Line context, chunk length, per-chunk beat counters and pointer advance.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      dst_ptr   <= '0;
      src_ptr   <= '0;
      remaining <= '0;
      mode      <= 1'b0;
      blend     <= 1'b0;
      clen      <= '0;
      rd_cnt    <= '0;
      pp_idx    <= '0;
      res_cnt   <= '0;
      wr_idx    <= '0;
    end else if (SOFT_RST) begin
      rd_cnt  <= '0;
      pp_idx  <= '0;
      res_cnt <= '0;
      wr_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: if (LINE_START) begin
          dst_ptr   <= LINE_ADDR_DST;
          src_ptr   <= LINE_ADDR_SRC;
          remaining <= LINE_LEN;
          mode      <= CMD_MODE;
          blend     <= PARAM_BLEND;
        end
        S_CHUNK: begin
          clen    <= (remaining >= 11'(BURST_MAX)) ? LW'(BURST_MAX) : LW'(remaining);
          rd_cnt  <= '0;
          pp_idx  <= '0;
          res_cnt <= '0;
          wr_idx  <= '0;
        end
        S_RD_DST_DAT, S_RD_SRC_DAT: if (RD_VALID) rd_cnt <= rd_last ? '0 : rd_cnt + ONE_L;
        S_PROC: begin
          if (PP_VALID && PP_READY) pp_idx <= pp_idx + ONE_L;
          if (res_take) res_cnt <= res_cnt + ONE_L;
        end
        S_WR_DAT: if (WR_DRD) begin
          if (wr_last) begin
            wr_idx    <= '0;
            dst_ptr   <= dst_ptr + (32'(clen) << 2);
            if (mode) src_ptr <= src_ptr + (32'(clen) << 2);
            remaining <= remaining - 11'(clen);
          end else begin
            wr_idx <= wr_idx + ONE_L;
          end
        end
        default: ;
      endcase
    end
  end

  // Chunk buffers; contents are only meaningful up to the live counters, so no reset.
  always_ff @(posedge CLK) begin
    if (!SOFT_RST && state == S_RD_DST_DAT && RD_VALID) dst_buf[rd_cnt[IW-1:0]] <= RD_DATA;
    if (!SOFT_RST && state == S_RD_SRC_DAT && RD_VALID) src_buf[rd_cnt[IW-1:0]] <= RD_DATA;
    if (!SOFT_RST && res_take) res_buf[res_cnt[IW-1:0]] <= RES_DATA;
  end

`ifdef DRW_LINECTRL_PERF_EN
  // Count every cycle spent on a line; the value holds until the next accepted kick.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST)                                          LINE_CYCLES <= '0;
    else if (state == S_IDLE && LINE_START && !SOFT_RST) LINE_CYCLES <= '0;
    else if (state != S_IDLE)                          LINE_CYCLES <= LINE_CYCLES + 32'd1;
  end
`endif

endmodule

// File: doc/drw_linectrl.md
Name: drw_linectrl

Overview:
Line-transfer responder for the draw pipeline. The main controller kicks one line; this block performs it.
- Splits the line into bursts of at most BURST_MAX pixels.
- Reads destination pixels (when blending) and texture pixels (BITBLT) from VRAM.
- Streams the pixel pairs to the pixel processor, collects the results and burst-writes them back to the destination.

Parameters:
BURST_MAX, 16, max pixels per memory burst and depth of each internal chunk buffer (power of 2, 2..64)
LW, 5, burst length width = log2(BURST_MAX)+1

Ports:
CLK  in  1  clock
ARST  in  1  reset, asynchronous, active-high
SOFT_RST  in  1  synchronous abort to IDLE
LINE_START  in  1  one-cycle line kick
LINE_BUSY  out  1  line in progress (combinational, see Behaviour)
LINE_ADDR_DST  in  32  destination byte address of first pixel
LINE_ADDR_SRC  in  32  texture byte address of first pixel
LINE_LEN  in  11  pixels in line, 0..2047
CMD_MODE  in  1  0 PATBLT, 1 BITBLT
PARAM_BLEND  in  1  1 = destination read required
RD_REQ  out  1  read burst request, held until RD_ACK
RD_ADDR  out  32  read burst byte address
RD_LEN  out  LW  read burst pixel count
RD_ACK  in  1  request accepted
RD_VALID  in  1  read data beat valid
RD_DATA  in  32  read data beat
PP_VALID  out  1  pixel pair to pixel processor
PP_DST  out  32  destination pixel (0 if not read)
PP_SRC  out  32  texture pixel (0 if PATBLT)
PP_READY  in  1  pixel processor accepts pair
RES_VALID  in  1  processed pixel valid, in order
RES_DATA  in  32  processed pixel
WR_REQ  out  1  write burst request, held until WR_ACK
WR_ADDR  out  32  write burst byte address
WR_LEN  out  LW  write burst pixel count
WR_ACK  in  1  write request accepted
WR_DATA  out  32  current write beat (first-word fall-through)
WR_DRD  in  1  memory consumed WR_DATA this cycle

Behaviour:
- Reset values: all outputs 0; state IDLE; internal addresses and counters 0.
- LINE_BUSY = (state != IDLE) | LINE_START. The kicker sees busy in the cycle after its registered kick.
- IDLE: on LINE_START, latch addresses, LINE_LEN, CMD_MODE and PARAM_BLEND.
  - LEN = 0 goes to DONE.
  - Otherwise goes to CHUNK.
  - Inputs are ignored while not IDLE.
- CHUNK: clen = min(remaining, BURST_MAX).
  - If blend, go to RD_DST; else if BITBLT, go to RD_SRC; else go to PROC.
- RD_DST: RD_REQ = 1, RD_ADDR = dst_ptr, RD_LEN = clen.
  - After RD_ACK, store clen RD_VALID beats into the dst buffer in order.
  - Then go to RD_SRC if BITBLT, else PROC.
- RD_SRC: same handshake, using src_ptr and the src buffer.
  - RD_VALID beats are accepted only in the data phase; beats arriving outside it are dropped.
- PROC: issue clen pairs with PP_VALID; index advances on PP_VALID & PP_READY.
  - Unused buffers supply 0.
  - RES_VALID beats are written into the result buffer independently. They may overlap issue and arrive up to any latency later.
  - Go to WR when the result count equals clen.
- WR: WR_REQ = 1 with WR_ADDR = dst_ptr, WR_LEN = clen. After WR_ACK, present results on WR_DATA.
  - Each WR_DRD advances the beat.
  - After clen beats: dst_ptr += clen*4; src_ptr += clen*4 (BITBLT only); remaining -= clen.
  - Then go to CHUNK if remaining ≠ 0, else DONE.
- DONE: one cycle, then IDLE. LINE_BUSY falls on leaving DONE.
- Address arithmetic: 32-bit modulo; wrap past 0xFFFFFFFC is not checked.
- SOFT_RST or ARST mid-line: immediate return to IDLE, REQs dropped, buffers invalidated. Any in-flight RD_VALID or RES_VALID beats after the abort are discarded.
- SOFT_RST together with LINE_START: SOFT_RST wins; the kick is lost.

Optional Feature:
DRW_LINECTRL_PERF_EN
- Defined: adds output LINE_CYCLES (32). A counter clears on an accepted LINE_START and increments every non-IDLE cycle. Its value holds after DONE until the next kick; reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- PATBLT, blend off, LEN=5, DST=0x2000_0000: no RD_REQ; 5 PP pairs with DST=SRC=0; one write burst with WR_LEN=5 at 0x2000_0000; LINE_BUSY low after DONE.
- BITBLT, blend on, LEN=40, BURST_MAX=16: per chunk a dst read then a src read, chunks of 16/16/8. WR_ADDR = DST, DST+0x40, DST+0x80 and RD src addresses SRC, SRC+0x40, SRC+0x80.
- LEN=0 kick: LINE_BUSY high in the kick cycle and for 1 DONE cycle; no memory traffic.
- Back-pressure: PP_READY toggling 1/0, RES latency 7, WR_DRD every 3rd cycle. The written data equals RES_DATA in order and the beat count matches WR_LEN.
- SOFT_RST asserted during RD_SRC data phase: RD_REQ/WR_REQ low next cycle, LINE_BUSY 0. A new kick with LEN=3 completes correctly.
- (PERF_EN) PATBLT LEN=1, all acks/readys immediate: LINE_CYCLES equals the non-IDLE cycle count measured by the bench.
